// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//
// Matrix keypad scanner for a ROWS x COLS keypad. One column strobe is driven
// at a time for SCAN_DIV cycles. Row inputs pass through a two-flop
// synchroniser before any decision is made. A key seen on a scan tick is
// debounced for DEBOUNCE stable cycles before it is accepted. Its release is
// debounced the same way. Scanning stays parked on the pressed key's column
// while the key is held, so presses in other columns are not seen until the
// release has been accepted.
//
// Ports
//   clk        clock
//   nrst       synchronous active-low reset
//   row_i      raw row sense, active-high, asynchronous to clk
//   col_o      one-hot column strobe, active-high, registered
//   key_code   col_idx*ROWS + row_idx of the last accepted key
//   key_valid  one-cycle pulse on an accepted press
//   key_held   high from acceptance until the debounced release
//   multi_err  one-cycle pulse when a scan tick sees more than one row
module keypad_scan_ctrl #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 20000,
  localparam int KW      = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [ROWS-1:0] row_i,
  output logic [COLS-1:0] col_o,
  output logic [KW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held,
  output logic            multi_err
);

  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  // +1 keeps the widths at least 1 bit when SCAN_DIV or DEBOUNCE is 1
  localparam int DIVW = $clog2(SCAN_DIV+1);
  localparam int DBW  = $clog2(DEBOUNCE+1);

  localparam logic [DIVW-1:0] DIV_MAX = DIVW'(SCAN_DIV-1);
  localparam logic [DBW-1:0]  DB_MAX  = DBW'(DEBOUNCE-1);
  localparam logic [CW-1:0]   COL_MAX = CW'(COLS-1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DB_PRESS = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_DB_REL   = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0] sync1_q, sync1_d;
  logic [ROWS-1:0] row_s_q, row_s_d;
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   col_idx_q, col_idx_d;
  logic [COLS-1:0] col_q, col_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DBW-1:0]  db_cnt_q, db_cnt_d;
  logic [KW-1:0]   key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic            multi_err_q, multi_err_d;

  // ---------------------------------------------------------------------------
  // Row decode helpers, all on the synchronised rows
  // ---------------------------------------------------------------------------
  logic            row_any;
  logic            row_onehot;
  logic [RW-1:0]   row_enc;
  logic [ROWS-1:0] row_sel;
  logic            row_match;   // exactly the latched row, nothing else
  logic            row_bit;     // latched row active, others don't care
  logic            tick;
  logic [CW-1:0]   col_next;
  logic [KW-1:0]   code_calc;

  always_comb begin
    row_any    = |row_s_q;
    // clearing the lowest set bit leaves zero only for a single set bit
    row_onehot = row_any && ((row_s_q & (row_s_q - ROWS'(1))) == '0);
    row_enc    = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_s_q[r]) row_enc = RW'(r);
    end
    row_sel    = ROWS'(1) << row_idx_q;
    row_match  = (row_s_q == row_sel);
    row_bit    = |(row_s_q & row_sel);
    tick       = (div_q == DIV_MAX);
    col_next   = (col_idx_q == COL_MAX) ? '0 : col_idx_q + CW'(1);
    // KW always covers CW and RW, so the product is formed without truncation
    code_calc  = KW'(col_idx_q) * KW'(ROWS) + KW'(row_idx_q);
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    sync1_d     = row_i;
    row_s_d     = sync1_q;
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    // The divider only counts in SCAN; holding it at zero elsewhere makes
    // every return to SCAN start a full column period.
    div_d       = '0;
    db_cnt_d    = db_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_err_d = 1'b0;

    case (state_q)
      ST_SCAN: begin
        div_d = tick ? '0 : div_q + DIVW'(1);
        if (tick) begin
          if (!row_any) begin
            col_idx_d = col_next;
          end else if (row_onehot) begin
            row_idx_d = row_enc;
            db_cnt_d  = '0;
            state_d   = ST_DB_PRESS;
          end else begin
            multi_err_d = 1'b1;
            col_idx_d   = col_next;
          end
        end
      end

      ST_DB_PRESS: begin
        if (row_match) begin
          if (db_cnt_q == DB_MAX) begin
            state_d     = ST_HELD;
            key_code_d  = code_calc;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + DBW'(1);
          end
        end else begin
          // bounce or a second row joined: rescan the same column
          state_d = ST_SCAN;
        end
      end

      ST_HELD: begin
        if (!row_bit) begin
          db_cnt_d = '0;
          state_d  = ST_DB_REL;
        end
      end

      ST_DB_REL: begin
        if (row_bit) begin
          state_d = ST_HELD;
        end else if (db_cnt_q == DB_MAX) begin
          key_held_d = 1'b0;
          col_idx_d  = col_next;
          state_d    = ST_SCAN;
        end else begin
          db_cnt_d = db_cnt_q + DBW'(1);
        end
      end

      default: state_d = ST_SCAN;
    endcase

    col_d = COLS'(1) << col_idx_d;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync1_q     <= '0;
      row_s_q     <= '0;
      state_q     <= ST_SCAN;
      col_idx_q   <= '0;
      col_q       <= COLS'(1);
      row_idx_q   <= '0;
      div_q       <= '0;
      db_cnt_q    <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      row_s_q     <= row_s_d;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      row_idx_q   <= row_idx_d;
      div_q       <= div_d;
      db_cnt_q    <= db_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_err_q <= multi_err_d;
    end
  end

  assign col_o     = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_err = multi_err_q;

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Parametrised matrix-keypad scanner for ROWS x COLS keypads. It drives one-hot column strobes at a programmable scan rate and synchronises the row inputs. Key presses and releases are debounced with a cycle-count filter. Multi-key presses within a column are rejected. The block sits between the keypad pins and the key-decode/display logic and emits one `key_valid` pulse per debounced press, plus a `key_held` level and a raw key index.

## Interface

Parameters:
- `ROWS`, default 4: number of row inputs; ≥2.
- `COLS`, default 4: number of column strobes; ≥2.
- `SCAN_DIV`, default 1000: clk cycles each column is driven while scanning; ≥1.
- `DEBOUNCE`, default 20000: consecutive stable cycles required to accept a press or a release; ≥1.

Ports (`KW` = $clog2(ROWS*COLS)):
- `clk`, in, 1: clock.
- `nrst`, in, 1: reset, synchronous, active-low.
- `row_i`, in, ROWS: raw row sense, active-high, asynchronous to clk.
- `col_o`, out, COLS: one-hot column strobe, active-high.
- `key_code`, out, KW: index of the last accepted key, `col_idx*ROWS + row_idx`.
- `key_valid`, out, 1: one-cycle pulse when a debounced press is accepted.
- `key_held`, out, 1: high from acceptance until the debounced release.
- `multi_err`, out, 1: one-cycle pulse when more than one row is active on a scan tick.

## Operation

Synchronisation and scan tick:
- `row_i` passes through a 2-flop synchroniser to give `row_s`. All decisions use `row_s` only.
- Divider counts 0..SCAN_DIV-1. `tick` is true when the divider is at SCAN_DIV-1. The divider runs only in SCAN and clears on every entry to SCAN.

States: SCAN, DB_PRESS, HELD, DB_REL. `col_o` = one-hot of `col_idx` in all states.

- **SCAN**, acting on `tick` only:
  - `row_s` == 0: `col_idx` advances, wrapping COLS-1 -> 0.
  - `row_s` one-hot: latch `row_idx`; `col_idx` holds; clear `db_cnt`; go to DB_PRESS.
  - More than one bit set: pulse `multi_err`; `col_idx` advances; stay in SCAN.
- **DB_PRESS**, evaluated every cycle:
  - `row_s` == onehot(`row_idx`) with `db_cnt` < DEBOUNCE-1: `db_cnt`++.
  - `row_s` == onehot(`row_idx`) with `db_cnt` == DEBOUNCE-1: go to HELD. On that same transition, register `key_code`, `key_valid`=1 and `key_held`=1.
  - Any mismatch, including an extra row: go to SCAN on the same column, no output.
- **HELD**:
  - `row_s[row_idx]`==0: clear `db_cnt`, go to DB_REL.
  - Other rows are ignored. No repeat pulses are generated.
- **DB_REL**:
  - `row_s[row_idx]`==1: go back to HELD. No new `key_valid`.
  - `row_s[row_idx]`==0 with `db_cnt` == DEBOUNCE-1: `key_held`=0; `col_idx` advances (wrap); go to SCAN.
  - Otherwise `db_cnt`++.
- `key_code` holds its value until the next accepted press.
- `db_cnt` width is $clog2(DEBOUNCE+1). `key_code` is computed at full width with no truncation for any legal ROWS/COLS.

## Timing

- **Reset**, when `nrst`=0 at a clk edge. Takes effect on the next cycle regardless of state, including mid-debounce or mid-HELD:
  - state SCAN, `col_idx`=0 (`col_o`=...0001);
  - divider=0, `db_cnt`=0, synchroniser flops=0;
  - `key_code`=0, `key_valid`=0, `key_held`=0, `multi_err`=0.
- Each column is driven for exactly SCAN_DIV cycles while scanning.
- All outputs are registered.
- Press latency:
  - A row change reaches `row_s` 2 cycles after `row_i` changes.
  - `key_valid` rises DEBOUNCE cycles after DB_PRESS entry.
  - DB_PRESS entry is the cycle after the tick that saw the key.
- Release latency: `key_held` falls DEBOUNCE cycles after DB_REL entry. DB_REL entry is 3 cycles after `row_i` falls (2-cycle synchroniser + HELD detect).
- `key_valid` and `multi_err` are never high together, and each lasts exactly 1 cycle.
- Bounce shorter than DEBOUNCE:
  - on press, no `key_valid` and scanning resumes;
  - on release, `key_held` stays 1.

## Test plan

Bench parameters: ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=8. Keypad model: `row_i[r]` = OR over c of (pressed[r][c] & `col_o[c]`).

1. Reset, then idle 32 cycles -> `col_o` = 0001,0010,0100,1000,0001,... with each value held 4 cycles; all other outputs 0.
2. Press (row 2, col 1) for 60 cycles, then release -> exactly one `key_valid`, `key_code`=6, `key_held`=1 until 8 cycles after DB_REL entry; next column driven = 0100.
3. Press (row 0, col 3) bouncing every 3 cycles for 24 cycles, then stable -> exactly one `key_valid`, `key_code`=12. Then a 5-cycle release glitch -> `key_held` stays 1, no second pulse.
4. Press rows 1 and 3 in col 0 together -> `multi_err` 1-cycle pulse on each col-0 tick, no `key_valid`, `col_o` keeps rotating.
5. `nrst`=0 for 1 cycle while HELD on key 6 -> next cycle `col_o`=0001, `key_held`=0, `key_code`=0. Key still pressed -> re-accepted on the next col-1 scan with `key_valid`.
6. Hold key 6, then press key 9 (row 1, col 2) -> no event for 9 while 6 is held. After 6 is released and debounced, key 9 is accepted: `key_code`=9.
